parity_monitor: RTL and testbench
=================================

Name: parity_monitor

Overview:
- Parametrised, registered successor to the single-lane 64-bit combinational parity checker.
- Checks NCH lanes of W-bit data per beat against received parity bits, with even/odd parity selectable at runtime.
- Reports per-beat errors, sticky per-lane error flags and a saturating error count.
- Sits on bus/memory read paths as a one-cycle-latency integrity monitor.

Parameters:
- W, 64, data bits per lane (W >= 1)
- NCH, 4, number of lanes (NCH >= 1)
- CNT_W, 16, width of error counter (CNT_W >= clog2(NCH+1))

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  beat qualifier for in_data/in_par
- in_data  input  NCH*W  lane k occupies bits [k*W +: W]
- in_par  input  NCH  received parity bit per lane
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with each beat
- err_clr  input  1  synchronous clear of err_sticky, err_cnt and cnt_sat
- out_valid  output  1  registered copy of in_valid
- out_par  output  NCH  registered computed parity per lane
- err_vec  output  NCH  registered per-lane mismatch for the beat; valid only when out_valid = 1
- err_sticky  output  NCH  per-lane flag, set on any error, held until err_clr
- err_cnt  output  CNT_W  saturating count of lane errors
- cnt_sat  output  1  high once err_cnt has reached all-ones

Behaviour:
- Reset (rst_n low, asynchronous): every output register is 0.
  - Covers out_valid, out_par, err_vec, err_sticky, err_cnt and cnt_sat.
  - Deassertion is the normal synchronous release; the first sampling edge after it is treated like any other edge.
- Per lane k, computed parity: p_k = (^in_data[k*W +: W]) XOR odd_mode.
  - With odd_mode = 1, an all-zero word produces parity 1.
- Pipeline: one register stage, latency 1 cycle from the in_valid edge to out_valid.
  - On each edge: out_valid <= in_valid.
  - When in_valid = 1: out_par <= p; err_vec <= p XOR in_par.
  - When in_valid = 0: out_par holds its previous value; err_vec <= 0.
- No backpressure: every valid beat is accepted; there is no ready signal.
- err_sticky: next = (err_clr ? 0 : err_sticky) | (in_valid ? (p XOR in_par) : 0).
  - If err_clr coincides with an erroring beat, the new error sets the flag.
- err_cnt: n = popcount of this beat's mismatches (0..NCH), or 0 when in_valid = 0.
  - base = err_clr ? 0 : err_cnt.
  - next = min(base + n, 2^CNT_W - 1), computed at CNT_W+1 bits with no wrap-around.
- cnt_sat: next = (next err_cnt == all-ones).
  - Cleared by err_clr only if that same cycle's n does not saturate again.
- odd_mode may change on any cycle; it only affects beats sampled on that edge. There is no state-machine flush.
- Reset asserted mid-stream drops any in-flight beat: out_valid is 0 immediately.
- X on in_data or in_par while in_valid = 0 must not propagate to err_sticky or err_cnt.

Optional Feature:
- Macro: PARITY_MONITOR_INJECT_EN.
- When defined:
  - Adds input inj_mask [NCH] and input inj_one_shot [1].
  - For lanes with inj_mask[k] = 1, p_k is inverted before the compare and the out_par register. This forces errors for diagnostics.
  - With inj_one_shot = 1, injection applies only to the first valid beat after inj_mask becomes nonzero. A one-bit armed register does this; it is cleared by reset and re-armed when inj_mask returns to 0.
- When undefined: the ports and the armed register are absent, and behaviour is exactly as above.

Test Plan:
- Reset and idle: W=64, NCH=4; hold rst_n low, then release with in_valid = 0 for 5 cycles -> all outputs 0 throughout.
- Basic parity: lane0 = 64'd32, other lanes = 0, in_par = 4'b0001, odd_mode = 0, one beat -> next cycle out_valid = 1, out_par = 4'b0001, err_vec = 0, err_cnt = 0.
- Odd mode and mismatch: the same data with odd_mode = 1 and in_par = 4'b0001 -> out_par = 4'b1110, err_vec = 4'b1111, err_sticky = 4'b1111, err_cnt = 4.
- Clear versus error collision: err_cnt = 4; assert err_clr on a beat with exactly lane2 in error -> err_sticky = 4'b0100, err_cnt = 1.
- Saturation: CNT_W = 3; feed beats with 4 errors each -> err_cnt goes 4, then 7 and stays 7 with cnt_sat = 1; err_clr on an idle cycle -> err_cnt = 0, cnt_sat = 0.
- Async reset mid-stream: assert rst_n low between edges during continuous valid beats -> out_valid, err_sticky and err_cnt go to 0 without waiting for a clock edge.
  - With PARITY_MONITOR_INJECT_EN: inj_mask = 4'b1000, inj_one_shot = 1 on clean data -> exactly one beat with err_vec = 4'b1000.

Source files
------------

// File: rtl/parity_monitor.sv
// parity_monitor: registered NCH-lane even/odd parity monitor with per-beat errors,
// sticky per-lane flags and a saturating error counter. Optional macro PARITY_MONITOR_INJECT_EN.
module parity_monitor #(
   parameter int W     = 64,
   parameter int NCH   = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [NCH*W-1:0]   in_data,
   input  logic [NCH-1:0]     in_par,
   input  logic               odd_mode,
   input  logic               err_clr,
`ifdef PARITY_MONITOR_INJECT_EN
   input  logic [NCH-1:0]     inj_mask,
   input  logic               inj_one_shot,
`endif
   output logic               out_valid,
   output logic [NCH-1:0]     out_par,
   output logic [NCH-1:0]     err_vec,
   output logic [NCH-1:0]     err_sticky,
   output logic [CNT_W-1:0]   err_cnt,
   output logic               cnt_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   function automatic logic lane_parity(input logic [W-1:0] word);
      return ^word;
   endfunction

   function automatic logic [CNT_W:0] pop_count(input logic [NCH-1:0] vec);
      logic [CNT_W:0] acc;
      acc = {(CNT_W+1){1'b0}};
      for (int i = 0; i < NCH; i++) begin
         acc = acc + {{CNT_W{1'b0}}, vec[i]};
      end
      return acc;
   endfunction

   logic [NCH-1:0]   inj_s;
   logic [NCH-1:0]   p_s;
   logic [NCH-1:0]   mism_s;
   logic [NCH-1:0]   sticky_next_s;
   logic [CNT_W:0]   base_s;
   logic [CNT_W:0]   sum_s;
   logic [CNT_W-1:0] cnt_next_s;

`ifdef PARITY_MONITOR_INJECT_EN
   logic inj_done_r;

   // Select which lanes get their computed parity flipped this beat
   always_comb begin
      inj_s = {NCH{1'b0}};
      if (inj_one_shot) begin
         if (inj_done_r) begin
            inj_s = {NCH{1'b0}};
         end else begin
            inj_s = inj_mask;
         end
      end else begin
         inj_s = inj_mask;
      end
   end

   // One-shot tracker: consumed by the first valid beat, re-armed once the mask drops to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_done_r <= 1'b0;
      end else if (inj_mask == {NCH{1'b0}}) begin
         inj_done_r <= 1'b0;
      end else if (in_valid) begin
         inj_done_r <= 1'b1;
      end else begin
         inj_done_r <= inj_done_r;
      end
   end
`else
   // No injection hardware in this build
   always_comb begin
      inj_s = {NCH{1'b0}};
   end
`endif

   // Per-lane computed parity and mismatch; idle beats contribute nothing so X data cannot leak
   always_comb begin
      p_s = {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) begin
         p_s[k] = lane_parity(in_data[k*W +: W]) ^ odd_mode ^ inj_s[k];
      end
      if (in_valid) begin
         mism_s = p_s ^ in_par;
      end else begin
         mism_s = {NCH{1'b0}};
      end
   end

   // Next sticky flags and saturating count; the sum is one bit wider so it cannot wrap
   always_comb begin
      if (err_clr) begin
         base_s        = {(CNT_W+1){1'b0}};
         sticky_next_s = mism_s;
      end else begin
         base_s        = {1'b0, err_cnt};
         sticky_next_s = err_sticky | mism_s;
      end
      sum_s = base_s + pop_count(mism_s);
      if (sum_s > {1'b0, CNT_MAX}) begin
         cnt_next_s = CNT_MAX;
      end else begin
         cnt_next_s = sum_s[CNT_W-1:0];
      end
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_par    <= {NCH{1'b0}};
         err_vec    <= {NCH{1'b0}};
         err_sticky <= {NCH{1'b0}};
         err_cnt    <= {CNT_W{1'b0}};
         cnt_sat    <= 1'b0;
      end else begin
         out_valid  <= in_valid;
         if (in_valid) begin
            out_par <= p_s;
         end else begin
            out_par <= out_par;
         end
         err_vec    <= mism_s;
         err_sticky <= sticky_next_s;
         err_cnt    <= cnt_next_s;
         cnt_sat    <= (cnt_next_s == CNT_MAX);
      end
   end

endmodule

// File: tb/tb_parity_monitor.sv
// tb_parity_monitor: table-driven directed vectors plus randomized beats checked against a
// behavioural model; a CNT_W=3 instance shares the stimulus to exercise saturation.
module tb_parity_monitor;

   localparam int W   = 64;
   localparam int NCH = 4;
   localparam int DW  = NCH * W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic [NCH-1:0]  in_par;
   logic            odd_mode;
   logic            err_clr;
`ifdef PARITY_MONITOR_INJECT_EN
   logic [NCH-1:0]  inj_mask;
   logic            inj_one_shot;
`endif

   logic            out_valid, out_valid3;
   logic [NCH-1:0]  out_par, out_par3;
   logic [NCH-1:0]  err_vec, err_vec3;
   logic [NCH-1:0]  err_sticky, err_sticky3;
   logic [15:0]     err_cnt;
   logic [2:0]      err_cnt3;
   logic            cnt_sat, cnt_sat3;

   always #5 clk = ~clk;

   parity_monitor #(.W(W), .NCH(NCH), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_par(in_par),
      .odd_mode(odd_mode), .err_clr(err_clr),
`ifdef PARITY_MONITOR_INJECT_EN
      .inj_mask(inj_mask), .inj_one_shot(inj_one_shot),
`endif
      .out_valid(out_valid), .out_par(out_par), .err_vec(err_vec),
      .err_sticky(err_sticky), .err_cnt(err_cnt), .cnt_sat(cnt_sat));

   parity_monitor #(.W(W), .NCH(NCH), .CNT_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_par(in_par),
      .odd_mode(odd_mode), .err_clr(err_clr),
`ifdef PARITY_MONITOR_INJECT_EN
      .inj_mask(4'b0000), .inj_one_shot(1'b0),
`endif
      .out_valid(out_valid3), .out_par(out_par3), .err_vec(err_vec3),
      .err_sticky(err_sticky3), .err_cnt(err_cnt3), .cnt_sat(cnt_sat3));

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic           m_valid;
   logic [NCH-1:0] m_par, m_err, m_sticky;
   int             m_cnt, m_cnt3;

   typedef struct {
      logic           valid;
      logic [DW-1:0]  data;
      logic [NCH-1:0] par;
      logic           odd;
      logic           clr;
      logic [NCH-1:0] e_par;
      logic [NCH-1:0] e_err;
      logic [NCH-1:0] e_sticky;
      int             e_cnt;
      int             e_cnt3;
      logic           e_sat3;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_par = 4'b0000; m_err = 4'b0000; m_sticky = 4'b0000;
      m_cnt = 0; m_cnt3 = 0;
   endtask

   // apply one beat, advance the model, and return #1 after the sampling edge
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NCH-1:0] p,
                        input logic o, input logic c);
      logic [NCH-1:0] pv, mv;
      in_valid = v;
      in_data  = v ? d : {DW{1'bx}};
      in_par   = v ? p : {NCH{1'bx}};
      odd_mode = o;
      err_clr  = c;
      for (int k = 0; k < NCH; k++) begin
         pv[k] = (($countones(d[k*W +: W]) % 2) == 1) ^ o;
      end
      mv = v ? (pv ^ p) : 4'b0000;
      m_valid = v;
      if (v) m_par = pv;
      m_err    = mv;
      m_sticky = (c ? 4'b0000 : m_sticky) | mv;
      m_cnt    = (c ? 0 : m_cnt) + $countones(mv);
      if (m_cnt > 65535) m_cnt = 65535;
      m_cnt3   = (c ? 0 : m_cnt3) + $countones(mv);
      if (m_cnt3 > 7) m_cnt3 = 7;
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".out_par"}, 32'(out_par), 32'(m_par));
      chk({tag, ".err_vec"}, 32'(err_vec), 32'(m_err));
      chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
      chk({tag, ".err_cnt"}, 32'(err_cnt), m_cnt);
      chk({tag, ".cnt_sat"}, 32'(cnt_sat), 32'(m_cnt == 65535));
      chk({tag, ".err_cnt3"}, 32'(err_cnt3), m_cnt3);
      chk({tag, ".cnt_sat3"}, 32'(cnt_sat3), 32'(m_cnt3 == 7));
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [DW-1:0] dr;
      logic [NCH-1:0] pr;

      d = {DW{1'b0}};
      d[5] = 1'b1;   // lane0 = 64'd32

      tbl[0] = '{1'b1, d, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1'b0};
      tbl[1] = '{1'b1, d, 4'b0001, 1'b1, 1'b0, 4'b1110, 4'b1111, 4'b1111, 4, 4, 1'b0};
      tbl[2] = '{1'b1, d, 4'b0101, 1'b0, 1'b1, 4'b0001, 4'b0100, 4'b0100, 1, 1, 1'b0};
      tbl[3] = '{1'b0, d, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0100, 1, 1, 1'b0};
      tbl[4] = '{1'b0, d, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1'b0};
      tbl[5] = '{1'b1, d, 4'b0001, 1'b1, 1'b0, 4'b1110, 4'b1111, 4'b1111, 4, 4, 1'b0};
      tbl[6] = '{1'b1, d, 4'b0001, 1'b1, 1'b0, 4'b1110, 4'b1111, 4'b1111, 8, 7, 1'b1};
      tbl[7] = '{1'b1, d, 4'b0001, 1'b1, 1'b0, 4'b1110, 4'b1111, 4'b1111, 12, 7, 1'b1};
      tbl[8] = '{1'b0, d, 4'b0000, 1'b0, 1'b1, 4'b1110, 4'b0000, 4'b0000, 0, 0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; in_data = {DW{1'b0}}; in_par = 4'b0000;
      odd_mode = 1'b0; err_clr = 1'b0;
`ifdef PARITY_MONITOR_INJECT_EN
      inj_mask = 4'b0000; inj_one_shot = 1'b0;
`endif
      model_reset();

      // reset and idle
      #22;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_par", 32'(out_par), 32'd0);
      chk("rst.err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, {DW{1'b0}}, 4'b0000, 1'b0, 1'b0);
         check_model("idle");
      end

      // directed table
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].valid, tbl[i].data, tbl[i].par, tbl[i].odd, tbl[i].clr);
         chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].valid));
         chk($sformatf("tbl%0d.out_par", i), 32'(out_par), 32'(tbl[i].e_par));
         chk($sformatf("tbl%0d.err_vec", i), 32'(err_vec), 32'(tbl[i].e_err));
         chk($sformatf("tbl%0d.err_sticky", i), 32'(err_sticky), 32'(tbl[i].e_sticky));
         chk($sformatf("tbl%0d.err_cnt", i), 32'(err_cnt), tbl[i].e_cnt);
         chk($sformatf("tbl%0d.cnt_sat", i), 32'(cnt_sat), 32'd0);
         chk($sformatf("tbl%0d.err_cnt3", i), 32'(err_cnt3), tbl[i].e_cnt3);
         chk($sformatf("tbl%0d.cnt_sat3", i), 32'(cnt_sat3), 32'(tbl[i].e_sat3));
      end

      // randomized beats against the model
      for (int i = 0; i < 400; i++) begin
         for (int j = 0; j < DW / 32; j++) begin
            dr[j*32 +: 32] = $urandom;
         end
         if ($urandom_range(0, 3) == 0) dr[W-1:0] = {W{1'b0}};
         pr = 4'($urandom);
         drive(($urandom_range(0, 3) != 0), dr, pr, 1'($urandom),
               ($urandom_range(0, 15) == 0));
         check_model("rand");
      end

      // async reset between edges during continuous errored beats
      drive(1'b1, d, 4'b0000, 1'b1, 1'b0);
      drive(1'b1, d, 4'b0000, 1'b1, 1'b0);
      chk("pre_arst.out_valid", 32'(out_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.out_valid", 32'(out_valid), 32'd0);
      chk("arst.err_sticky", 32'(err_sticky), 32'd0);
      chk("arst.err_cnt", 32'(err_cnt), 32'd0);
      chk("arst.cnt_sat3", 32'(cnt_sat3), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      drive(1'b1, d, 4'b0001, 1'b0, 1'b0);
      check_model("post_arst");

`ifdef PARITY_MONITOR_INJECT_EN
      begin
         int hits;
         hits = 0;
         inj_mask = 4'b1000;
         inj_one_shot = 1'b1;
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, d, 4'b0001, 1'b0, 1'b0);
            if (err_vec == 4'b1000) hits++;
         end
         chk("inj.one_shot_hits", 32'(hits), 32'd1);
         inj_mask = 4'b0000;
         drive(1'b0, d, 4'b0000, 1'b0, 1'b0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
